// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01
  } arb_state_t;

  localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set bit of req scanning ptr, ptr+1, ... with wrap.
module rr_pick #(
  parameter int N = 2
) (
  input  logic [2**N-1:0] req,
  input  logic [N-1:0]    ptr,
  output logic            found,
  output logic [2**N-1:0] winner,
  output logic [N-1:0]    winner_idx
);

  localparam int R = 2**N;

  logic [2*R-1:0] req_dbl;
  logic [R-1:0]   req_rot;
  logic [N-1:0]   enc;

  assign req_dbl = {req, req} >> ptr;
  assign req_rot = req_dbl[R-1:0];

  // Lowest set bit of the rotated vector is the highest-priority requester.
  always_comb begin
    enc = '0;
    for (int i = R - 1; i >= 0; i--) begin
      if (req_rot[i]) enc = N'(i);
    end
  end

  assign found      = |req;
  assign winner_idx = enc + ptr;
  assign winner     = found ? (R'(1) << winner_idx) : '0;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter over 2**N requesters with registered one-hot grant and binary grant_id.
// Define ARB_TIMEOUT_EN to force a release after TIMEOUT busy cycles and pulse timeout.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N       = 2,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [2**N-1:0] req,
  input  logic            done,
  output logic [2**N-1:0] grant,
  output logic [N-1:0]    grant_id,
  output logic            grant_valid,
  output logic            timeout,
  output arb_state_t      state
);

  localparam int R = 2**N;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("rr_arbiter: TIMEOUT must be in 2..255");
  end

  // valid/ready: a requester holds req[i] high until it is done; grant_valid marks
  // ownership, and ownership ends on done or when the owner drops its req bit.
  arb_state_t     state_q, state_d;
  logic [N-1:0]   ptr_q, ptr_d;
  logic [R-1:0]   grant_d;
  logic [N-1:0]   id_d;
  logic           valid_d;
  logic           pick_found;
  logic [R-1:0]   pick_onehot;
  logic [N-1:0]   pick_idx;
  logic           release_norm;
  logic           release_force;
  logic           hold_expired;

  rr_pick #(.N(N)) u_pick (
    .req        (req),
    .ptr        (ptr_q),
    .found      (pick_found),
    .winner     (pick_onehot),
    .winner_idx (pick_idx)
  );

  assign state         = state_q;
  assign release_norm  = (state_q == BUSY) && (done || !req[grant_id]);
  assign release_force = (state_q == BUSY) && !release_norm && hold_expired;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant;
    id_d    = grant_id;
    valid_d = grant_valid;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BUSY;
          grant_d = pick_onehot;
          id_d    = pick_idx;
          valid_d = 1'b1;
        end else begin
          grant_d = '0;
          id_d    = '0;
          valid_d = 1'b0;
        end
      end
      BUSY: begin
        if (release_norm || release_force) begin
          state_d = IDLE;
          grant_d = '0;
          id_d    = '0;
          valid_d = 1'b0;
          ptr_d   = grant_id + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        id_d    = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant       <= grant_d;
      grant_id    <= id_d;
      grant_valid <= valid_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q;

  assign hold_expired = (cnt_q == 8'(TIMEOUT - 1));
  assign timeout      = timeout_q;

  // Counter is held at zero in IDLE so it starts from zero on the first BUSY cycle.
  always_comb begin
    cnt_d = '0;
    if (state_q == BUSY) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= release_force;
    end
  end
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Round-robin arbiter that shares one resource among 2**N requesters.
- Uses a rotating-priority pick, so no requester starves.
- Grants are one-hot with a matching binary ID, held until the owner releases.
- Sits in front of shared datapath resources; the binary grant_id drives the resource's select/mux input.

Parameters:
- N, 2, log2 of requester count; 2**N request lines.
- TIMEOUT, 16, max grant hold cycles; used only when ARB_TIMEOUT_EN is defined; legal range 2..255.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- req  input  2**N  request vector; bit i = requester i wants the resource
- done  input  1  owner's release strobe; sampled only while grant_valid=1
- grant  output  2**N  one-hot grant, registered
- grant_id  output  N  binary index of the owner, registered
- grant_valid  output  1  high while a grant is held
- timeout  output  1  one-cycle pulse on forced release; tied 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset: one clock, asynchronous active-low reset_n.
  - state=IDLE, ptr=0, grant=0, grant_id=0, grant_valid=0, timeout=0, hold counter=0.
- State IDLE:
  - If req != 0, pick the winner with the rotating scan ptr, ptr+1, … 2**N-1, 0, … ptr-1. The first set bit wins.
  - Register grant, grant_id and grant_valid=1, then move to BUSY.
  - Latency: req sampled at edge k gives the grant visible after edge k, i.e. 1 cycle.
  - If req == 0, stay in IDLE; outputs stay 0.
- State BUSY:
  - Grant outputs are stable. req of other requesters is ignored.
  - Release occurs when done=1 OR req[grant_id]=0 (owner withdrew).
  - On release, at the next edge: grant=0, grant_valid=0, ptr <= (grant_id+1) mod 2**N (wraps 2**N-1 -> 0), state=IDLE.
  - Each release is followed by one dead cycle (IDLE) before the next grant. Back-to-back ownership by the same requester is therefore never consecutive cycles.
- Invariants:
  - grant is always zero or one-hot, and equals 1<<grant_id when grant_valid=1.
  - ptr changes only on release.
- Simultaneous events:
  - done while in IDLE is ignored.
  - done together with the owner dropping req is a single release.
  - reset_n low at any point, including mid-BUSY, forces reset values immediately (asynchronous); ptr returns to 0.
- Illegal state encoding: returns to IDLE with outputs cleared.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on grant and increments each BUSY cycle.
  - When the count reaches TIMEOUT-1 with no release, the next edge forces a release (same ptr update as a normal release) and pulses timeout=1 for one cycle.
  - A normal release in the same cycle takes precedence: no timeout pulse.
- Not defined: no counter logic; timeout is constant 0; grants are held indefinitely.

Decomposition:
- Package arb_pkg:
  - state enum typedef (IDLE, BUSY) in 2-bit logic.
  - constant for the default TIMEOUT.
- Sub-module rr_pick, combinational:
  - Inputs: req and ptr. Outputs: found, one-hot winner and binary winner index.
  - Implementation: rotate req right by ptr, priority-encode the lowest set bit, rotate the index back (add ptr mod 2**N).
- rr_arbiter holds the FSM, ptr, output registers and the optional counter.

Test Plan:
- Reset/idle: reset_n=0 then 1, req=4'b0000 for 5 cycles -> grant=0, grant_id=0, grant_valid=0 throughout.
- Rotation: ptr=0, req=4'b1010 held, done pulsed each grant -> grant_id sequence 1, 3, 1, 3. A dead cycle between each grant; ptr goes 2, 0 (wrap), 2.
- Withdraw: grant to 2 with req=4'b0100, then req drops to 4'b0001 without done -> release next edge, then grant_id=0 after the dead cycle.
- Full contention: req=4'b1111, done pulsed each grant -> grant_id 0, 1, 2, 3, 0; grant always one-hot.
- Reset mid-operation: in BUSY with grant_id=3, assert reset_n=0 between edges -> outputs 0 immediately. After deassert with req=4'b1000 -> grant_id=3 again (ptr=0 scan).
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=4): req=4'b0001 held, no done -> grant_valid high 4 cycles, then timeout=1 for one cycle with grant_valid=0. Re-grant to 0 after the dead cycle. Without the macro: grant held for 100 cycles and timeout=0.
